spi_flash_pad_arbiter: RTL and testbench

SPI_FLASH_PAD_ARBITER -- requirements
Module: spi_flash_pad_arbiter

---
 rtl/spi_flash_pad_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_spi_flash_pad_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_pad_arbiter.sv
// Flash pad arbiter: shares one SPI flash pad set between the CPU master and a debug bridge.
// Optional feature macro SPI_ARB_TIMEOUT_EN bounds debug tenure and requires dbg_req re-arm after a forced exit.
`timescale 1ns/1ps
module spi_flash_pad_arbiter #(
  parameter int          GUARD_CYCLES   = 4,
  parameter int          PARK_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       ext_clk,
  input  logic       ext_rst,
  input  logic       cpu_cs_n,
  input  logic       cpu_clk,
  input  logic [3:0] cpu_sdat_o,
  input  logic [3:0] cpu_sdat_oe,
  output logic [3:0] cpu_sdat_i,
  input  logic       dbg_req,
  output logic       dbg_gnt,
  input  logic       dbg_cs_n,
  input  logic       dbg_clk,
  input  logic [3:0] dbg_sdat_o,
  input  logic [3:0] dbg_sdat_oe,
  output logic [3:0] dbg_sdat_i,
  output logic       pad_cs_n,
  output logic       pad_clk,
  output logic [3:0] pad_sdat_o,
  output logic [3:0] pad_sdat_oeb,
  input  logic [3:0] pad_sdat_i,
  output logic       cpu_conflict,
  output logic       dbg_timeout,
  input  logic       flag_clr
);

  localparam int IW = $clog2(GUARD_CYCLES + 1);
  localparam int PW = $clog2(PARK_CYCLES + 1);
  localparam logic [IW-1:0] GUARD_LIM = IW'(GUARD_CYCLES);
  localparam logic [PW-1:0] PARK_LOAD = PW'(PARK_CYCLES);
  localparam logic [15:0]   TMO_LIM   = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    CPU_OWN     = 2'd0,
    PARK_TO_DBG = 2'd1,
    DBG_OWN     = 2'd2,
    PARK_TO_CPU = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [PW-1:0] park_cnt_q, park_cnt_d;
  logic          dbg_gnt_q, dbg_gnt_d;
  logic          cpu_conflict_q, cpu_conflict_d;
  logic          tmo_exit;
  logic          grant_ok;

  function automatic logic [IW-1:0] idle_sat_inc(input logic [IW-1:0] v);
    return (v >= GUARD_LIM) ? GUARD_LIM : v + IW'(1);
  endfunction

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] tenure_cnt_q, tenure_cnt_d;
  logic        rearm_q, rearm_d;
  logic        dbg_timeout_q, dbg_timeout_d;

  always_comb begin
    tenure_cnt_d  = '0;
    tmo_exit      = 1'b0;
    rearm_d       = rearm_q;
    dbg_timeout_d = dbg_timeout_q;
    if (state_q == DBG_OWN) begin
      tenure_cnt_d = (tenure_cnt_q == 16'hFFFF) ? tenure_cnt_q : tenure_cnt_q + 16'd1;
      // Forced exit waits for the debug master to be between transactions.
      tmo_exit = (({1'b0, tenure_cnt_q} + 17'd1) >= {1'b0, TMO_LIM}) && dbg_cs_n;
    end
    if (tmo_exit) begin
      rearm_d = 1'b1;
    end else if (!dbg_req) begin
      rearm_d = 1'b0;
    end
    if (tmo_exit) begin
      dbg_timeout_d = 1'b1;
    end else if (flag_clr) begin
      dbg_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge ext_clk) begin
    if (!ext_rst) begin
      tenure_cnt_q  <= '0;
      rearm_q       <= 1'b0;
      dbg_timeout_q <= 1'b0;
    end else begin
      tenure_cnt_q  <= tenure_cnt_d;
      rearm_q       <= rearm_d;
      dbg_timeout_q <= dbg_timeout_d;
    end
  end

  assign grant_ok    = ~rearm_q;
  assign dbg_timeout = dbg_timeout_q;
`else
  // Debug tenure is unbounded in this build; the flag is a constant 0.
  assign tmo_exit    = 1'b0;
  assign grant_ok    = 1'b1;
  assign dbg_timeout = 1'b0 && (TMO_LIM != 16'd0);
`endif

  always_comb begin
    state_d    = state_q;
    park_cnt_d = park_cnt_q;
    idle_cnt_d = cpu_cs_n ? idle_sat_inc(idle_cnt_q) : '0;
    case (state_q)
      CPU_OWN: begin
        // Only pre-empt a CPU that has been deselected long enough to be between transactions.
        if (dbg_req && grant_ok && cpu_cs_n && (idle_cnt_q >= GUARD_LIM)) begin
          state_d    = PARK_TO_DBG;
          park_cnt_d = PARK_LOAD;
        end
      end
      PARK_TO_DBG: begin
        if (park_cnt_q <= PW'(1)) begin
          state_d    = DBG_OWN;
          park_cnt_d = '0;
        end else begin
          park_cnt_d = park_cnt_q - PW'(1);
        end
      end
      DBG_OWN: begin
        if ((!dbg_req && dbg_cs_n) || tmo_exit) begin
          state_d    = PARK_TO_CPU;
          park_cnt_d = PARK_LOAD;
        end
      end
      PARK_TO_CPU: begin
        if (park_cnt_q <= PW'(1)) begin
          state_d    = CPU_OWN;
          park_cnt_d = '0;
          idle_cnt_d = '0;
        end else begin
          park_cnt_d = park_cnt_q - PW'(1);
        end
      end
      default: begin
        state_d    = CPU_OWN;
        park_cnt_d = '0;
      end
    endcase
    dbg_gnt_d = (state_d == DBG_OWN);
    if (!cpu_cs_n && (state_q != CPU_OWN)) begin
      cpu_conflict_d = 1'b1;
    end else if (flag_clr) begin
      cpu_conflict_d = 1'b0;
    end else begin
      cpu_conflict_d = cpu_conflict_q;
    end
  end

  always_ff @(posedge ext_clk) begin
    if (!ext_rst) begin
      state_q        <= CPU_OWN;
      idle_cnt_q     <= '0;
      park_cnt_q     <= '0;
      dbg_gnt_q      <= 1'b0;
      cpu_conflict_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      park_cnt_q     <= park_cnt_d;
      dbg_gnt_q      <= dbg_gnt_d;
      cpu_conflict_q <= cpu_conflict_d;
    end
  end

  // Pad mux decodes the registered state directly so ownership changes take effect the same cycle.
  always_comb begin
    pad_cs_n     = 1'b1;
    pad_clk      = 1'b0;
    pad_sdat_o   = 4'h0;
    pad_sdat_oeb = 4'hF;
    cpu_sdat_i   = 4'h0;
    dbg_sdat_i   = 4'h0;
    case (state_q)
      CPU_OWN: begin
        pad_cs_n     = cpu_cs_n;
        pad_clk      = cpu_clk;
        pad_sdat_o   = cpu_sdat_o;
        pad_sdat_oeb = ~cpu_sdat_oe;
        cpu_sdat_i   = pad_sdat_i;
      end
      DBG_OWN: begin
        pad_cs_n     = dbg_cs_n;
        pad_clk      = dbg_clk;
        pad_sdat_o   = dbg_sdat_o;
        pad_sdat_oeb = ~dbg_sdat_oe;
        dbg_sdat_i   = pad_sdat_i;
      end
      default: begin
      end
    endcase
  end

  assign dbg_gnt      = dbg_gnt_q;
  assign cpu_conflict = cpu_conflict_q;

endmodule

// File: tb/tb_spi_flash_pad_arbiter.sv
// Scoreboard bench for spi_flash_pad_arbiter: directed vectors push expected pad/flag state, a negedge monitor compares.
`timescale 1ns/1ps
module tb_spi_flash_pad_arbiter;

  localparam int M_CPU  = 0;
  localparam int M_PARK = 1;
  localparam int M_DBG  = 2;

  logic       ext_clk = 1'b0;
  logic       ext_rst;
  logic       cpu_cs_n, cpu_clk;
  logic [3:0] cpu_sdat_o, cpu_sdat_oe, cpu_sdat_i;
  logic       dbg_req, dbg_gnt, dbg_cs_n, dbg_clk;
  logic [3:0] dbg_sdat_o, dbg_sdat_oe, dbg_sdat_i;
  logic       pad_cs_n, pad_clk;
  logic [3:0] pad_sdat_o, pad_sdat_oeb, pad_sdat_i;
  logic       cpu_conflict, dbg_timeout, flag_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       cs_n;
    logic       clk;
    logic [3:0] so;
    logic [3:0] oeb;
    logic [3:0] ci;
    logic [3:0] di;
    logic       gnt;
    logic       conf;
    logic       tmo;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 ext_clk = ~ext_clk;

  spi_flash_pad_arbiter #(
    .GUARD_CYCLES  (4),
    .PARK_CYCLES   (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .ext_clk     (ext_clk),
    .ext_rst     (ext_rst),
    .cpu_cs_n    (cpu_cs_n),
    .cpu_clk     (cpu_clk),
    .cpu_sdat_o  (cpu_sdat_o),
    .cpu_sdat_oe (cpu_sdat_oe),
    .cpu_sdat_i  (cpu_sdat_i),
    .dbg_req     (dbg_req),
    .dbg_gnt     (dbg_gnt),
    .dbg_cs_n    (dbg_cs_n),
    .dbg_clk     (dbg_clk),
    .dbg_sdat_o  (dbg_sdat_o),
    .dbg_sdat_oe (dbg_sdat_oe),
    .dbg_sdat_i  (dbg_sdat_i),
    .pad_cs_n    (pad_cs_n),
    .pad_clk     (pad_clk),
    .pad_sdat_o  (pad_sdat_o),
    .pad_sdat_oeb(pad_sdat_oeb),
    .pad_sdat_i  (pad_sdat_i),
    .cpu_conflict(cpu_conflict),
    .dbg_timeout (dbg_timeout),
    .flag_clr    (flag_clr)
  );

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Push the expected outputs for the current cycle, then advance to just after the next edge.
  task automatic chk(input int m, input logic g, input logic c, input logic t, input string nm);
    exp_t e;
    e.cs_n = 1'b1; e.clk = 1'b0; e.so = 4'h0; e.oeb = 4'hF; e.ci = 4'h0; e.di = 4'h0;
    if (m == M_CPU) begin
      e.cs_n = cpu_cs_n; e.clk = cpu_clk; e.so = cpu_sdat_o; e.oeb = ~cpu_sdat_oe; e.ci = pad_sdat_i;
    end else if (m == M_DBG) begin
      e.cs_n = dbg_cs_n; e.clk = dbg_clk; e.so = dbg_sdat_o; e.oeb = ~dbg_sdat_oe; e.di = pad_sdat_i;
    end
    e.gnt = g; e.conf = c; e.tmo = t;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge ext_clk);
    #1;
  endtask

  task automatic chk_n(input int n, input int m, input logic g, input logic c, input logic t,
                       input string nm);
    for (int k = 0; k < n; k++) chk(m, g, c, t, nm);
  endtask

  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge ext_clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        cmp({nm, ".pad_cs_n"},     {3'b0, pad_cs_n},     {3'b0, e.cs_n});
        cmp({nm, ".pad_clk"},      {3'b0, pad_clk},      {3'b0, e.clk});
        cmp({nm, ".pad_sdat_o"},   pad_sdat_o,           e.so);
        cmp({nm, ".pad_sdat_oeb"}, pad_sdat_oeb,         e.oeb);
        cmp({nm, ".cpu_sdat_i"},   cpu_sdat_i,           e.ci);
        cmp({nm, ".dbg_sdat_i"},   dbg_sdat_i,           e.di);
        cmp({nm, ".dbg_gnt"},      {3'b0, dbg_gnt},      {3'b0, e.gnt});
        cmp({nm, ".cpu_conflict"}, {3'b0, cpu_conflict}, {3'b0, e.conf});
        cmp({nm, ".dbg_timeout"},  {3'b0, dbg_timeout},  {3'b0, e.tmo});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100us");
    $fatal(1);
  end

  initial begin
    cpu_cs_n = 1'b1; cpu_clk = 1'b0; cpu_sdat_o = 4'h0; cpu_sdat_oe = 4'h0;
    dbg_req = 1'b0; dbg_cs_n = 1'b1; dbg_clk = 1'b0; dbg_sdat_o = 4'h0; dbg_sdat_oe = 4'h0;
    pad_sdat_i = 4'h0; flag_clr = 1'b0; ext_rst = 1'b0;
    @(posedge ext_clk);
    #1;
    chk(M_CPU, 0, 0, 0, "reset");
    ext_rst = 1'b1;

    // CPU traffic with a busy but unowned debug port
    dbg_cs_n = 1'b0; dbg_clk = 1'b1; dbg_sdat_o = 4'hA; dbg_sdat_oe = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cpu_cs_n = 1'b0; cpu_clk = i[0]; cpu_sdat_o = 4'(i + 3);
      cpu_sdat_oe = (i < 2) ? 4'h1 : 4'h0; pad_sdat_i = 4'(9 + i);
      chk(M_CPU, 0, 0, 0, "cpu_traffic");
    end

    // Guard window, then grant with two parked cycles
    cpu_cs_n = 1'b1; cpu_clk = 1'b0; dbg_cs_n = 1'b1; dbg_clk = 1'b0;
    chk_n(4, M_CPU, 0, 0, 0, "guard_idle");
    dbg_req = 1'b1;
    chk(M_CPU, 0, 0, 0, "req_cycle");
    chk_n(2, M_PARK, 0, 0, 0, "park_to_dbg");

    // Debug ownership with CPU intrusion and sticky-flag handling
    dbg_cs_n = 1'b0; dbg_clk = 1'b1; dbg_sdat_o = 4'h5; dbg_sdat_oe = 4'hF; pad_sdat_i = 4'h9;
    chk(M_DBG, 1, 0, 0, "dbg_own");
    cpu_cs_n = 1'b0; cpu_clk = 1'b1; cpu_sdat_o = 4'hF; cpu_sdat_oe = 4'hF;
    chk(M_DBG, 1, 0, 0, "cpu_intrude");
    cpu_cs_n = 1'b1;
    chk(M_DBG, 1, 1, 0, "conflict_set");
    cpu_cs_n = 1'b0; flag_clr = 1'b1;
    chk(M_DBG, 1, 1, 0, "clr_vs_set");
    cpu_cs_n = 1'b1;
    chk(M_DBG, 1, 1, 0, "set_wins");
    flag_clr = 1'b0;
    chk(M_DBG, 1, 0, 0, "conflict_clr");

    // Release while the debug master is mid-transaction
    dbg_req = 1'b0;
    chk_n(2, M_DBG, 1, 0, 0, "hold_busy");
    dbg_cs_n = 1'b1; dbg_clk = 1'b0;
    chk(M_DBG, 1, 0, 0, "busy_end");
    chk_n(2, M_PARK, 0, 0, 0, "park_to_cpu");

    // Guard restarts from zero on return; dropping dbg_req in park does not abort it
    dbg_req = 1'b1;
    chk_n(5, M_CPU, 0, 0, 0, "idle_cleared");
    dbg_req = 1'b0;
    chk_n(2, M_PARK, 0, 0, 0, "park_no_abort");
    chk(M_DBG, 1, 0, 0, "grant_after_drop");
    chk_n(2, M_PARK, 0, 0, 0, "park_back");

    // Request during a long CPU transaction must wait for the guard window
    dbg_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_cs_n = 1'b0; cpu_clk = i[0]; cpu_sdat_o = 4'(i); cpu_sdat_oe = 4'h0;
      pad_sdat_i = 4'(15 - i);
      chk(M_CPU, 0, 0, 0, "no_truncate");
    end
    cpu_cs_n = 1'b1; cpu_clk = 1'b0;
    chk_n(5, M_CPU, 0, 0, 0, "guard_after_busy");
    chk_n(2, M_PARK, 0, 0, 0, "park3");

`ifdef SPI_ARB_TIMEOUT_EN
    chk_n(16, M_DBG, 1, 0, 0, "tenure");
    chk_n(2, M_PARK, 0, 0, 1, "tmo_park");
    chk_n(6, M_CPU, 0, 0, 1, "no_regrant");
    dbg_req = 1'b0;
    chk(M_CPU, 0, 0, 1, "req_low");
    dbg_req = 1'b1;
    chk(M_CPU, 0, 0, 1, "req_high");
    chk_n(2, M_PARK, 0, 0, 1, "regrant_park");
    flag_clr = 1'b1;
    chk(M_DBG, 1, 0, 1, "regrant");
    flag_clr = 1'b0; dbg_req = 1'b0;
    chk(M_DBG, 1, 0, 0, "tmo_clr");
    chk_n(2, M_PARK, 0, 0, 0, "park4");
`else
    chk_n(30, M_DBG, 1, 0, 0, "unbounded");
    dbg_req = 1'b0;
    chk(M_DBG, 1, 0, 0, "release");
    chk_n(2, M_PARK, 0, 0, 0, "park4");
`endif

    // Reset in the middle of a debug tenure
    dbg_req = 1'b1;
    chk_n(5, M_CPU, 0, 0, 0, "regrant_guard");
    chk_n(2, M_PARK, 0, 0, 0, "park5");
    cpu_cs_n = 1'b0;
    chk(M_DBG, 1, 0, 0, "dbg_again");
    cpu_cs_n = 1'b1; ext_rst = 1'b0;
    chk(M_DBG, 1, 1, 0, "pre_reset");
    ext_rst = 1'b1; dbg_req = 1'b0;
    chk(M_CPU, 0, 0, 0, "post_reset");
    chk(M_CPU, 0, 0, 0, "settled");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge ext_clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
